// File: rtl/riscv_branch_pkg.sv
// rtl/riscv_branch_pkg.sv - shared types and funct3 encodings for branch redirect control
//
// Contents:
//   br_state_t       redirect sequencer states (IDLE, REDIRECT, FLUSH)
//   F3_*             RV32I conditional-branch funct3 encodings
//   F3_ILLEGAL_SAFE  funct3 presented to branch_control when no legal branch is qualified
//   f3_is_legal()    1 for the six conditional-branch encodings, 0 for 010/011
package riscv_branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } br_state_t;

    localparam logic [2:0] F3_BEQ          = 3'b000;
    localparam logic [2:0] F3_BNE          = 3'b001;
    localparam logic [2:0] F3_BLT          = 3'b100;
    localparam logic [2:0] F3_BGE          = 3'b101;
    localparam logic [2:0] F3_BLTU         = 3'b110;
    localparam logic [2:0] F3_BGEU         = 3'b111;
    localparam logic [2:0] F3_ILLEGAL_SAFE = 3'b010;

    // 010 and 011 are the only unused funct3 values in the branch opcode space.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3[2:1] != 2'b01);
    endfunction

endpackage

// File: rtl/branch_stat_counter.sv
// rtl/branch_stat_counter.sv - saturating event counter for branch statistics
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset, clears count
//   inc    in   1  add one this cycle (ignored once count is all-ones)
//   count  out  W  current count, sticks at all-ones
module branch_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - taken-branch resolution, fetch redirect and wrong-path flush
//
// Optional feature macro: BRANCH_STATS_EN (adds saturating stat_total / stat_taken counters;
// without it both outputs are tied to zero and no counter flops exist).
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   ex_valid, ex_is_branch, ex_funct3  EX-stage branch qualification
//   ex_rs1, ex_rs2, ex_target          EX operands and computed target
//   b_control, r1, r2                  to branch_control comparator
//   branch_sel                         from branch_control, 1 = condition true
//   redirect_valid/_pc/_ready          redirect handshake to fetch
//   flush_ifid, flush_idex             wrong-path flush of IF/ID and ID/EX
//   busy                               sequencer not idle; EX results are wrong-path
//   misalign_err                       one-cycle pulse for a taken, misaligned target
//   stat_total, stat_taken             branch statistics
module branch_redirect_ctrl
    import riscv_branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_target,
    output logic [2:0]       b_control,
    output logic [XLEN-1:0]  r1,
    output logic [XLEN-1:0]  r2,
    input  logic             branch_sel,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_taken
);

    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    br_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic qualified;
    logic legal;
    logic taken;
    logic aligned;
    logic handshake;

    // Only an idle sequencer looks at EX; anything arriving while busy is wrong-path.
    assign qualified = ex_valid & ex_is_branch & (state_q == IDLE);
    assign legal     = f3_is_legal(ex_funct3);
    assign taken     = qualified & legal & branch_sel;
    assign aligned   = (ex_target[1:0] == 2'b00);
    assign handshake = (state_q == REDIRECT) & redirect_ready;

    // Steer the comparator to a harmless encoding unless a legal branch is being resolved.
    assign b_control = (qualified && legal) ? ex_funct3 : F3_ILLEGAL_SAFE;
    assign r1        = ex_rs1;
    assign r2        = ex_rs2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (taken && aligned) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            redirect_pc  <= '0;
            misalign_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            misalign_err <= taken & ~aligned;
            if (taken && aligned) begin
                redirect_pc <= ex_target;
            end
        end
    end

    // Outputs are pure decodes of the state register, so they change only on clock edges.
    assign redirect_valid = (state_q == REDIRECT);
    assign busy           = (state_q != IDLE);
    assign flush_ifid     = busy;
    assign flush_idex     = busy;

`ifdef BRANCH_STATS_EN
    branch_stat_counter #(.W(CNT_W)) u_stat_total (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (qualified & legal),
        .count (stat_total)
    );

    branch_stat_counter #(.W(CNT_W)) u_stat_taken (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (handshake),
        .count (stat_taken)
    );
`else
    assign stat_total = '0;
    assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

`ifdef BRANCH_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid, ex_is_branch;
    logic [2:0]    ex_funct3;
    logic [31:0]   ex_rs1, ex_rs2, ex_target;
    logic [2:0]    b_control;
    logic [31:0]   r1, r2;
    logic          branch_sel;
    logic          sel_force;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          redirect_ready;
    logic          flush_ifid, flush_idex, busy, misalign_err;
    logic [CW-1:0] stat_total, stat_taken;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_funct3      (ex_funct3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_target      (ex_target),
        .b_control      (b_control),
        .r1             (r1),
        .r2             (r2),
        .branch_sel     (branch_sel),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .busy           (busy),
        .misalign_err   (misalign_err),
        .stat_total     (stat_total),
        .stat_taken     (stat_taken)
    );

    // Reference branch_control comparator; sel_force models a comparator asserting anyway.
    function automatic logic cmp_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign branch_sel = sel_force | cmp_model(b_control, r1, r2);

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] tgt);
        ex_valid     = v;
        ex_is_branch = v;
        ex_funct3    = f3;
        ex_rs1       = a;
        ex_rs2       = b;
        ex_target    = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if ({redirect_valid, flush_ifid, flush_idex, busy, misalign_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {redirect_valid, flush_ifid, flush_idex, busy, misalign_err});
        end
        checks++;
        if (redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc got=%h want=0", redirect_pc);
        end
        checks++;
        if (stat_total !== '0 || stat_taken !== '0) begin
            failures++;
            $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_total, stat_taken);
        end
        checks++;
        if (b_control !== 3'b010) begin
            failures++;
            $display("FAIL reset_bctl got=%b want=010", b_control);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_beq_taken();
        logic [31:0] exp;
        drive(1'b1, 3'b000, 32'hF000_0000, 32'hF000_0000, 32'h0000_0100);
        exp_q.push_back(32'h0000_0100);
        #1;
        checks++;
        if (b_control !== 3'b000 || r1 !== 32'hF000_0000 || r2 !== 32'hF000_0000) begin
            failures++;
            $display("FAIL beq_bctl got=%b r1=%h r2=%h want=000", b_control, r1, r2);
        end
        cyc();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
            failures++;
            $display("FAIL beq_redirect got=%b pc=%h want=1 pc=%h", redirect_valid, redirect_pc, exp);
        end
        checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL beq_flush_redirect got=%b%b%b want=111", flush_ifid, flush_idex, busy);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if (redirect_valid !== 1'b0 || flush_ifid !== 1'b1 || flush_idex !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL beq_flush%0d got=%b%b%b%b want=0111", k,
                         redirect_valid, flush_ifid, flush_idex, busy);
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || flush_ifid !== 1'b0) begin
            failures++;
            $display("FAIL beq_idle got=%b%b want=00", busy, flush_ifid);
        end
    endtask

    task automatic test_bne_not_taken();
        drive(1'b1, 3'b001, 32'hF000_0000, 32'hF000_0000, 32'h0000_0200);
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 0) drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
            checks++;
            if (redirect_valid !== 1'b0 || flush_ifid !== 1'b0 || flush_idex !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL bne_quiet%0d got=%b%b%b%b want=0000", k,
                         redirect_valid, flush_ifid, flush_idex, busy);
            end
        end
    endtask

    task automatic test_blt_backpressure();
        logic [31:0] exp;
        redirect_ready = 1'b0;
        drive(1'b1, 3'b100, 32'hF000_0000, 32'hFFFF_FFFF, 32'h0000_0ABC);
        exp_q.push_back(32'h0000_0ABC);
        cyc();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        exp = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) redirect_ready = 1'b1;
            #1;
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== exp || busy !== 1'b1) begin
                failures++;
                $display("FAIL blt_hold%0d got=%b pc=%h want=1 pc=%h", k, redirect_valid, redirect_pc, exp);
            end
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (redirect_valid !== 1'b0 || flush_idex !== 1'b1) begin
                failures++;
                $display("FAIL blt_flush%0d got=%b%b want=01", k, redirect_valid, flush_idex);
            end
            cyc();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL blt_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_misalign_and_illegal();
        drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h0000_0102);
        cyc();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        checks++;
        if (misalign_err !== 1'b1 || redirect_valid !== 1'b0 || busy !== 1'b0 || flush_ifid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse got=%b%b%b%b want=1000",
                     misalign_err, redirect_valid, busy, flush_ifid);
        end
        cyc();
        checks++;
        if (misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_one_cycle got=%b want=0", misalign_err);
        end
        sel_force = 1'b1;
        drive(1'b1, 3'b011, 32'h5, 32'h5, 32'h0000_0300);
        #1;
        checks++;
        if (b_control !== 3'b010) begin
            failures++;
            $display("FAIL illegal_bctl got=%b want=010", b_control);
        end
        cyc();
        sel_force = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        checks++;
        if (redirect_valid !== 1'b0 || busy !== 1'b0 || misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_none got=%b%b%b want=000", redirect_valid, busy, misalign_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        drive(1'b1, 3'b110, 32'h1, 32'h2, 32'h0000_1000);
        exp_q.push_back(32'h0000_1000);
        cyc();
        // second taken branch presented during REDIRECT and FLUSH must be ignored
        drive(1'b1, 3'b000, 32'h7, 32'h7, 32'h0000_2000);
        #1;
        checks++;
        if (b_control !== 3'b010) begin
            failures++;
            $display("FAIL b2b_bctl_busy got=%b want=010", b_control);
        end
        exp = exp_q.pop_front();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
            failures++;
            $display("FAIL b2b_first got=%b pc=%h want=1 pc=%h", redirect_valid, redirect_pc, exp);
        end
        cyc();
        cyc();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        cyc();
        checks++;
        if (busy !== 1'b0 || redirect_pc !== exp || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_second_ignored got=busy%b pc=%h q=%0d want=busy0 pc=%h q=0",
                     busy, redirect_pc, exp_q.size(), exp);
        end
    endtask

    task automatic test_reset_in_flush();
        drive(1'b1, 3'b000, 32'h9, 32'h9, 32'h0000_3000);
        cyc();
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        cyc();
        checks++;
        if (busy !== 1'b1 || redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstflush_pre got=%b%b want=10", busy, redirect_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({redirect_valid, flush_ifid, flush_idex, busy} !== 4'b0 || redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL rstflush_async got=%b pc=%h want=0000 pc=0",
                     {redirect_valid, flush_ifid, flush_idex, busy}, redirect_pc);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstflush_idle got=%b%b want=00", busy, redirect_valid);
        end
    endtask

    task automatic test_stats();
`ifdef BRANCH_STATS_EN
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h0000_4000 + 32'(n * 4));
            cyc();
            drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
            cyc();
            cyc();
            cyc();
        end
        checks++;
        if (stat_taken !== 2'd3 || stat_total !== 2'd3) begin
            failures++;
            $display("FAIL stats_sat got=%0d/%0d want=3/3", stat_total, stat_taken);
        end
`else
        checks++;
        if (stat_total !== '0 || stat_taken !== '0) begin
            failures++;
            $display("FAIL stats_tied got=%0d/%0d want=0/0", stat_total, stat_taken);
        end
`endif
    endtask

    initial begin
        sel_force      = 1'b0;
        redirect_ready = 1'b1;
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_blt_backpressure();
        test_misalign_and_illegal();
        test_back_to_back();
        test_reset_in_flush();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
